custom_inst_axi_seq: RTL and testbench

//  Single-outstanding AXI4 burst sequencer for the custom-instruction block. Accepts one

---
 rtl/custom_inst_axi_pkg.sv | 24 ++
 rtl/custom_inst_axi_seq.sv | 260 ++++++++++++++++++++++++++
 tb/tb_custom_inst_axi_seq.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/custom_inst_axi_pkg.sv
// Shared types and constants for the custom-instruction AXI4 burst sequencer.
// Holds the FSM state enum, AXI response/burst encodings and the 4KB page size.
package custom_inst_axi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_AW,
    S_W,
    S_B,
    S_DONE
  } seq_state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam int unsigned AXI_4KB_BYTES = 4096;

endpackage

// File: rtl/custom_inst_axi_seq.sv
// Single-outstanding AXI4 INCR burst sequencer: one cmd in, flat m_axi_* out,
// beat streams to/from requester pass straight through, status on done_*.
module custom_inst_axi_seq
  import custom_inst_axi_pkg::*;
#(
  parameter int unsigned IdWidth   = 1,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned AxiId     = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  // command
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic                   cmd_write_i,
  input  logic [AddrWidth-1:0]   cmd_addr_i,
  input  logic [7:0]             cmd_len_i,
  // write beats
  input  logic [DataWidth-1:0]   wr_data_i,
  input  logic [DataWidth/8-1:0] wr_strb_i,
  input  logic                   wr_valid_i,
  output logic                   wr_ready_o,
  // read beats
  output logic [DataWidth-1:0]   rd_data_o,
  output logic                   rd_last_o,
  output logic                   rd_valid_o,
  input  logic                   rd_ready_i,
  // completion
  output logic                   done_valid_o,
  output logic                   done_err_o,
  input  logic                   done_ready_i,
  // AXI AR
  output logic [IdWidth-1:0]     m_axi_arid,
  output logic [AddrWidth-1:0]   m_axi_araddr,
  output logic [7:0]             m_axi_arlen,
  output logic [2:0]             m_axi_arsize,
  output logic [1:0]             m_axi_arburst,
  output logic                   m_axi_arvalid,
  input  logic                   m_axi_arready,
  // AXI R
  input  logic [IdWidth-1:0]     m_axi_rid,
  input  logic [DataWidth-1:0]   m_axi_rdata,
  input  logic [1:0]             m_axi_rresp,
  input  logic                   m_axi_rlast,
  input  logic                   m_axi_rvalid,
  output logic                   m_axi_rready,
  // AXI AW
  output logic [IdWidth-1:0]     m_axi_awid,
  output logic [AddrWidth-1:0]   m_axi_awaddr,
  output logic [7:0]             m_axi_awlen,
  output logic [2:0]             m_axi_awsize,
  output logic [1:0]             m_axi_awburst,
  output logic                   m_axi_awvalid,
  input  logic                   m_axi_awready,
  // AXI W
  output logic [DataWidth-1:0]   m_axi_wdata,
  output logic [DataWidth/8-1:0] m_axi_wstrb,
  output logic                   m_axi_wlast,
  output logic                   m_axi_wvalid,
  input  logic                   m_axi_wready,
  // AXI B
  input  logic [IdWidth-1:0]     m_axi_bid,
  input  logic [1:0]             m_axi_bresp,
  input  logic                   m_axi_bvalid,
  output logic                   m_axi_bready
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned SizeLog   = $clog2(StrbWidth);
  localparam logic [2:0]  AxSize    = 3'(SizeLog);

  seq_state_e r_state;
  seq_state_e w_state_nxt;

  logic [AddrWidth-1:0] r_addr;
  logic [7:0]           r_len;
  logic [7:0]           r_cnt;
  logic                 r_err;

  logic [20:0] w_span;
  logic        w_cross;
  logic        w_cmd_hs;
  logic        w_r_hs;
  logic        w_w_hs;
  logic        w_b_hs;
  logic        w_done_hs;
  logic        w_cnt_last;
  logic        w_rlast_bad;
  logic        w_unused;

  // Page-end check done wide enough that no len/width combination wraps.
  assign w_span = 21'(cmd_addr_i[11:0])
                + ((21'(cmd_len_i) + 21'd1) << SizeLog);
  assign w_cross = w_span > 21'(AXI_4KB_BYTES);

  assign w_cnt_last = (r_cnt == r_len);

  assign w_cmd_hs  = cmd_valid_i & cmd_ready_o;
  assign w_r_hs    = m_axi_rvalid & m_axi_rready;
  assign w_w_hs    = m_axi_wvalid & m_axi_wready;
  assign w_b_hs    = m_axi_bvalid & m_axi_bready;
  assign w_done_hs = done_valid_o & done_ready_i;

  assign w_rlast_bad = m_axi_rlast != w_cnt_last;

  // Address channels always show the registered command.
  assign m_axi_arid    = IdWidth'(AxiId);
  assign m_axi_araddr  = r_addr;
  assign m_axi_arlen   = r_len;
  assign m_axi_arsize  = AxSize;
  assign m_axi_arburst = AXI_BURST_INCR;

  assign m_axi_awid    = IdWidth'(AxiId);
  assign m_axi_awaddr  = r_addr;
  assign m_axi_awlen   = r_len;
  assign m_axi_awsize  = AxSize;
  assign m_axi_awburst = AXI_BURST_INCR;

  assign m_axi_wdata = wr_data_i;
  assign m_axi_wstrb = wr_strb_i;
  assign rd_data_o   = m_axi_rdata;

  assign done_err_o = done_valid_o & r_err;

  // IDs are fixed and single-outstanding, so returned IDs carry no info.
  assign w_unused = ^{m_axi_rid, m_axi_bid};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    cmd_ready_o   = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    rd_valid_o    = 1'b0;
    rd_last_o     = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    wr_ready_o    = 1'b0;
    m_axi_bready  = 1'b0;
    done_valid_o  = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          if (w_cross) begin
            w_state_nxt = S_DONE;
          end else if (cmd_write_i) begin
            w_state_nxt = S_AW;
          end else begin
            w_state_nxt = S_AR;
          end
        end
      end
      S_AR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) begin
          w_state_nxt = S_R;
        end
      end
      S_R: begin
        m_axi_rready = rd_ready_i;
        rd_valid_o   = m_axi_rvalid;
        rd_last_o    = w_cnt_last;
        // Stop on slave rlast or our own last beat so no
        // beat beyond len is ever taken.
        if (m_axi_rvalid && rd_ready_i
            && (m_axi_rlast || w_cnt_last)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_AW: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) begin
          w_state_nxt = S_W;
        end
      end
      S_W: begin
        m_axi_wvalid = wr_valid_i;
        wr_ready_o   = m_axi_wready;
        m_axi_wlast  = w_cnt_last;
        if (wr_valid_i && m_axi_wready && w_cnt_last) begin
          w_state_nxt = S_B;
        end
      end
      S_B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done_valid_o = 1'b1;
        if (done_ready_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Keep every handshake quiet while reset is held.
    if (rst_i) begin
      w_state_nxt   = S_IDLE;
      cmd_ready_o   = 1'b0;
      m_axi_arvalid = 1'b0;
      m_axi_rready  = 1'b0;
      rd_valid_o    = 1'b0;
      rd_last_o     = 1'b0;
      m_axi_awvalid = 1'b0;
      m_axi_wvalid  = 1'b0;
      m_axi_wlast   = 1'b0;
      wr_ready_o    = 1'b0;
      m_axi_bready  = 1'b0;
      done_valid_o  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_addr <= '0;
      r_len  <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_cmd_hs) begin
        r_addr <= cmd_addr_i;
        r_len  <= cmd_len_i;
        r_cnt  <= '0;
        r_err  <= w_cross;
      end
      if (w_r_hs) begin
        r_cnt <= r_cnt + 8'd1;
        if (m_axi_rresp != AXI_RESP_OKAY || w_rlast_bad) begin
          r_err <= 1'b1;
        end
      end
      if (w_w_hs) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_b_hs && m_axi_bresp != AXI_RESP_OKAY) begin
        r_err <= 1'b1;
      end
      if (w_done_hs) begin
        r_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_custom_inst_axi_seq.sv
// Directed bench for custom_inst_axi_seq with an inline AXI4 memory slave.
// Vector table for single transactions plus hand-written corner sequences.
module tb_custom_inst_axi_seq;

  logic        clk;
  logic        rst_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_write_i;
  logic [31:0] cmd_addr_i;
  logic [7:0]  cmd_len_i;
  logic [31:0] wr_data_i;
  logic [3:0]  wr_strb_i;
  logic        wr_valid_i;
  logic        wr_ready_o;
  logic [31:0] rd_data_o;
  logic        rd_last_o;
  logic        rd_valid_o;
  logic        rd_ready_i;
  logic        done_valid_o;
  logic        done_err_o;
  logic        done_ready_i;
  logic [0:0]  m_axi_arid;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [0:0]  m_axi_rid;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic [0:0]  m_axi_awid;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [0:0]  m_axi_bid;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;

  custom_inst_axi_seq dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_write_i(cmd_write_i), .cmd_addr_i(cmd_addr_i),
    .cmd_len_i(cmd_len_i),
    .wr_data_i(wr_data_i), .wr_strb_i(wr_strb_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .rd_data_o(rd_data_o), .rd_last_o(rd_last_o),
    .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
    .done_valid_o(done_valid_o), .done_err_o(done_err_o),
    .done_ready_i(done_ready_i),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr),
    .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- AXI memory slave ----------------
  logic [31:0] mem [0:1023];
  int          s_ar_delay;
  int          s_err_beat;
  int          s_early_last;
  logic [1:0]  s_bresp;
  int          s_ar_wait;
  bit          s_rd_act, s_wr_act, s_b_pend;
  int          s_rbeat, s_wbeat;
  logic [9:0]  s_rbase, s_wbase, s_idx;
  logic [7:0]  s_rlen;
  int          ar_cnt, aw_cnt;
  logic [7:0]  cap_arlen;
  logic [2:0]  cap_arsize;
  logic [1:0]  cap_arburst;
  bit          ar_unstable, hold_v;
  logic [31:0] hold_araddr;
  logic [7:0]  hold_arlen;
  bit          sn_rst, sn_ar, sn_arvalid, sn_r, sn_rlast;
  bit          sn_aw, sn_w, sn_wlast, sn_b;
  logic [31:0] sn_araddr, sn_awaddr, sn_wdata;
  logic [7:0]  sn_arlen;
  logic [2:0]  sn_arsize;
  logic [1:0]  sn_arburst;
  logic [3:0]  sn_wstrb;

  initial begin
    s_ar_delay = 0; s_err_beat = -1; s_early_last = -1;
    s_bresp = 2'b00; s_ar_wait = 0;
    s_rd_act = 0; s_wr_act = 0; s_b_pend = 0;
    s_rbeat = 0; s_wbeat = 0; s_rbase = '0; s_wbase = '0;
    s_rlen = '0; ar_cnt = 0; aw_cnt = 0;
    ar_unstable = 0; hold_v = 0;
    sn_rst = 1; sn_ar = 0; sn_arvalid = 0; sn_r = 0; sn_rlast = 0;
    sn_aw = 0; sn_w = 0; sn_wlast = 0; sn_b = 0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0;
    m_axi_rresp = 0; m_axi_rlast = 0; m_axi_rid = '0;
    m_axi_awready = 0; m_axi_wready = 0;
    m_axi_bvalid = 0; m_axi_bresp = 0; m_axi_bid = '0;
    forever begin
      @(negedge clk);
      if (sn_rst) begin
        s_rd_act = 0; s_wr_act = 0; s_b_pend = 0; s_ar_wait = 0;
      end else begin
        if (sn_ar) begin
          s_rbase = sn_araddr[11:2]; s_rlen = sn_arlen;
          s_rbeat = 0; s_rd_act = 1; ar_cnt++;
          cap_arlen = sn_arlen; cap_arsize = sn_arsize;
          cap_arburst = sn_arburst; s_ar_wait = 0;
        end else if (sn_arvalid) begin
          s_ar_wait++;
        end
        if (sn_r) begin
          if (sn_rlast) s_rd_act = 0;
          s_rbeat++;
        end
        if (sn_aw) begin
          s_wbase = sn_awaddr[11:2]; s_wbeat = 0;
          s_wr_act = 1; aw_cnt++;
        end
        if (sn_w) begin
          s_idx = s_wbase + 10'(s_wbeat);
          for (int b = 0; b < 4; b++)
            if (sn_wstrb[b]) mem[s_idx][b*8 +: 8] = sn_wdata[b*8 +: 8];
          s_wbeat++;
          if (sn_wlast) begin s_wr_act = 0; s_b_pend = 1; end
        end
        if (sn_b) s_b_pend = 0;
      end
      s_idx = s_rbase + 10'(s_rbeat);
      m_axi_arready = (s_ar_wait >= s_ar_delay);
      m_axi_rvalid  = s_rd_act;
      m_axi_rdata   = s_rd_act ? mem[s_idx] : 32'h0;
      m_axi_rresp   = (s_rd_act && s_rbeat == s_err_beat) ? 2'b10 : 2'b00;
      m_axi_rlast   = s_rd_act && (s_rbeat == int'(s_rlen)
                                   || s_rbeat == s_early_last);
      m_axi_awready = 1'b1;
      m_axi_wready  = s_wr_act;
      m_axi_bvalid  = s_b_pend;
      m_axi_bresp   = s_bresp;
      #2;
      sn_rst     = rst_i;
      sn_ar      = m_axi_arvalid && m_axi_arready;
      sn_arvalid = m_axi_arvalid;
      sn_araddr  = m_axi_araddr;
      sn_arlen   = m_axi_arlen;
      sn_arsize  = m_axi_arsize;
      sn_arburst = m_axi_arburst;
      sn_r       = m_axi_rvalid && m_axi_rready;
      sn_rlast   = m_axi_rlast;
      sn_aw      = m_axi_awvalid && m_axi_awready;
      sn_awaddr  = m_axi_awaddr;
      sn_w       = m_axi_wvalid && m_axi_wready;
      sn_wlast   = m_axi_wlast;
      sn_wdata   = m_axi_wdata;
      sn_wstrb   = m_axi_wstrb;
      sn_b       = m_axi_bvalid && m_axi_bready;
      if (m_axi_arvalid && !m_axi_arready) begin
        if (hold_v && (m_axi_araddr != hold_araddr
                       || m_axi_arlen != hold_arlen))
          ar_unstable = 1;
        hold_v = 1; hold_araddr = m_axi_araddr; hold_arlen = m_axi_arlen;
      end else begin
        hold_v = 0;
      end
    end
  end

  // ---------------- requester tasks ----------------
  task automatic send_cmd(input logic wr, input logic [31:0] addr,
                          input logic [7:0] len);
    bit ok;
    ok = 0;
    @(negedge clk);
    cmd_valid_i = 1; cmd_write_i = wr; cmd_addr_i = addr; cmd_len_i = len;
    for (int i = 0; i < 20; i++) begin
      #2;
      if (cmd_ready_o) begin ok = 1; break; end
      @(negedge clk);
    end
    chk("cmd_accept", 32'(ok), 32'd1);
    @(negedge clk);
    cmd_valid_i = 0;
  endtask

  task automatic run_read(input logic [7:0] len, input bit toggle,
                          input logic [31:0] base,
                          output int nb, output logic err);
    bit done;
    nb = 0; err = 0; done = 0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      rd_ready_i = toggle ? (cyc % 2 == 0) : 1'b1;
      done_ready_i = 1;
      #2;
      if (rd_valid_o && rd_ready_i) begin
        chk("rd_data", rd_data_o, base + 32'(nb));
        chk("rd_last", 32'(rd_last_o), 32'(nb == int'(len)));
        nb++;
      end
      if (done_valid_o) begin err = done_err_o; done = 1; end
      @(negedge clk);
    end
    rd_ready_i = 0; done_ready_i = 0;
    if (!done) chk("rd_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_write(input logic [7:0] len, input logic [31:0] base,
                           output int nb, output logic err);
    bit done;
    nb = 0; err = 0; done = 0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      wr_valid_i = (nb <= int'(len));
      wr_data_i = base + 32'(nb);
      wr_strb_i = 4'hF;
      done_ready_i = 1;
      #2;
      if (wr_valid_i && wr_ready_o) begin
        chk("wlast", 32'(m_axi_wlast), 32'(nb == int'(len)));
        nb++;
      end
      if (done_valid_o) begin err = done_err_o; done = 1; end
      @(negedge clk);
    end
    wr_valid_i = 0; done_ready_i = 0;
    if (!done) chk("wr_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [31:0] base;
    int          err_beat;
    logic [1:0]  bresp;
    logic        exp_err;
    int          exp_beats;
    int          exp_bus;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int nb, ar0, aw0;
    logic err;
    logic [9:0] w;

    vecs[0] = '{0, 32'h100, 8'd3, 32'hA0,       -1, 2'd0, 0, 4, 1};
    vecs[1] = '{1, 32'h200, 8'd0, 32'hDEADBEEF, -1, 2'd0, 0, 1, 1};
    vecs[2] = '{0, 32'h200, 8'd0, 32'hDEADBEEF, -1, 2'd0, 0, 1, 1};
    vecs[3] = '{0, 32'hFF8, 8'd3, 32'h0,        -1, 2'd0, 1, 0, 0};
    vecs[4] = '{1, 32'hFF8, 8'd3, 32'h11110000, -1, 2'd0, 1, 0, 0};
    vecs[5] = '{0, 32'h300, 8'd1, 32'hC0DE00C0,  0, 2'd0, 1, 2, 1};
    vecs[6] = '{1, 32'h300, 8'd1, 32'h55550000, -1, 2'd3, 1, 2, 1};
    vecs[7] = '{0, 32'hFF0, 8'd3, 32'hC0DE03FC, -1, 2'd0, 0, 4, 1};
    vecs[8] = '{0, 32'hFF4, 8'd3, 32'h0,        -1, 2'd0, 1, 0, 0};
    vecs[9] = '{1, 32'hFFC, 8'd0, 32'h12345678, -1, 2'd0, 0, 1, 1};

    for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE0000 | 32'(i);
    for (int i = 0; i < 4; i++) mem[16'h40 + i] = 32'hA0 + 32'(i);

    rst_i = 1; cmd_valid_i = 0; cmd_write_i = 0; cmd_addr_i = '0;
    cmd_len_i = '0; wr_data_i = '0; wr_strb_i = '0; wr_valid_i = 0;
    rd_ready_i = 0; done_ready_i = 0;

    repeat (3) @(negedge clk);
    #2;
    chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd0);
    chk("rst_valids",
        32'({m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready,
             m_axi_bready, rd_valid_o, wr_ready_o, done_valid_o}), 32'd0);
    @(negedge clk);
    rst_i = 0;
    #2;
    chk("idle_cmd_ready", 32'(cmd_ready_o), 32'd1);

    foreach (vecs[k]) begin
      s_err_beat = vecs[k].err_beat;
      s_bresp = vecs[k].bresp;
      ar0 = ar_cnt; aw0 = aw_cnt;
      send_cmd(vecs[k].wr, vecs[k].addr, vecs[k].len);
      if (vecs[k].wr) run_write(vecs[k].len, vecs[k].base, nb, err);
      else run_read(vecs[k].len, 0, vecs[k].base, nb, err);
      chk($sformatf("v%0d_err", k), 32'(err), 32'(vecs[k].exp_err));
      chk($sformatf("v%0d_beats", k), 32'(nb), 32'(vecs[k].exp_beats));
      chk($sformatf("v%0d_bus", k),
          32'(vecs[k].wr ? aw_cnt - aw0 : ar_cnt - ar0),
          32'(vecs[k].exp_bus));
      if (!vecs[k].wr && vecs[k].exp_bus != 0) begin
        chk("arlen", 32'(cap_arlen), 32'(vecs[k].len));
        chk("arsize", 32'(cap_arsize), 32'd2);
        chk("arburst", 32'(cap_arburst), 32'd1);
      end
      if (vecs[k].wr && vecs[k].exp_bus != 0) begin
        w = vecs[k].addr[11:2];
        for (int b = 0; b <= int'(vecs[k].len); b++)
          chk("wr_mem", mem[w + 10'(b)], vecs[k].base + 32'(b));
      end
      s_err_beat = -1; s_bresp = 2'b00;
    end

    // Backpressure: slow arready plus 1010 rd_ready.
    s_ar_delay = 5;
    ar_unstable = 0;
    send_cmd(0, 32'h100, 8'd3);
    run_read(8'd3, 1, 32'hA0, nb, err);
    chk("bp_err", 32'(err), 32'd0);
    chk("bp_beats", 32'(nb), 32'd4);
    chk("bp_ar_stable", 32'(ar_unstable), 32'd0);
    s_ar_delay = 0;

    // Slave ends the burst early on beat 1 of 4.
    s_early_last = 1;
    send_cmd(0, 32'h100, 8'd3);
    run_read(8'd3, 0, 32'hA0, nb, err);
    chk("early_err", 32'(err), 32'd1);
    chk("early_beats", 32'(nb), 32'd2);
    s_early_last = -1;

    // Reset after two of four write beats.
    send_cmd(1, 32'h200, 8'd3);
    nb = 0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      wr_valid_i = 1; wr_data_i = 32'h77770000 + 32'(nb); wr_strb_i = 4'hF;
      #2;
      if (wr_valid_i && wr_ready_o) nb++;
      if (nb == 2) break;
      @(negedge clk);
    end
    chk("rst_beats_before", 32'(nb), 32'd2);
    @(negedge clk);
    rst_i = 1; wr_valid_i = 0;
    @(negedge clk);
    #2;
    chk("midrst_valids",
        32'({m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready,
             m_axi_bready, rd_valid_o, wr_ready_o, done_valid_o}), 32'd0);
    chk("midrst_cmd_ready", 32'(cmd_ready_o), 32'd0);
    @(negedge clk);
    rst_i = 0;
    #2;
    chk("post_rst_ready", 32'(cmd_ready_o), 32'd1);
    send_cmd(0, 32'h100, 8'd3);
    run_read(8'd3, 0, 32'hA0, nb, err);
    chk("post_rst_err", 32'(err), 32'd0);
    chk("post_rst_beats", 32'(nb), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
